// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- RAM BIST controller: FSM states, per-element
// descriptors and default geometry.
package ram_bist_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W0_UP   = 3'd1,
    R0W1_UP = 3'd2,
    R1W0_UP = 3'd3,
    R0W1_DN = 3'd4,
    R1W0_DN = 3'd5,
    R0_UP   = 3'd6,
    DONE    = 3'd7
  } state_t;

  typedef struct packed {
    logic down;     // address sweep direction
    logic rd;       // element reads and compares
    logic exp_one;  // expected read value is all-ones
    logic wr;       // element writes
    logic wr_one;   // written value is all-ones
  } elem_t;

  function automatic elem_t elem_desc(input state_t s);
    case (s)
      W0_UP:   return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      R0W1_UP: return '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      R1W0_UP: return '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      R0W1_DN: return '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      R1W0_DN: return '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      R0_UP:   return '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      default: return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic state_t next_elem(input state_t s);
    case (s)
      W0_UP:   return R0W1_UP;
      R0W1_UP: return R1W0_UP;
      R1W0_UP: return R0W1_DN;
      R0W1_DN: return R1W0_DN;
      R1W0_DN: return R0_UP;
      default: return DONE;
    endcase
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter for the BIST sweep, with first/last flags
// that follow the direction chosen at load time.
module ram_bist_addr_gen #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          down,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          first,
  output logic          last
);

  logic dir;

  // Counter and direction register; load jumps to the sweep's start address.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= {AW{1'b0}};
      dir  <= 1'b0;
    end else if (load) begin
      dir  <= down;
      addr <= down ? {AW{1'b1}} : {AW{1'b0}};
    end else if (step) begin
      addr <= dir ? (addr - AW'(1)) : (addr + AW'(1));
    end else begin
      addr <= addr;
    end
  end

  assign first = dir ? (addr == {AW{1'b1}}) : (addr == {AW{1'b0}});
  assign last  = dir ? (addr == {AW{1'b0}}) : (addr == {AW{1'b1}});

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller. Define RAM_BIST_ERR_COUNT_EN to add err_cnt and
// run to completion on mismatch; otherwise the test stops at the first mismatch.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data
`ifdef RAM_BIST_ERR_COUNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  state_t state, state_nxt;
  elem_t desc, desc_nxt;
  logic phase, phase_nxt;  // 0 = read/write cycle A, 1 = compare cycle B
  logic ag_load, ag_down, ag_step;
  logic [AW-1:0] addr;
  logic last, first_unused;
  logic active, accept, cmp_active, mismatch, fail_seen;
  logic [DW-1:0] exp_val;

  ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (ag_load),
    .down  (ag_down),
    .step  (ag_step),
    .addr  (addr),
    .first (first_unused),
    .last  (last)
  );

  assign desc       = elem_desc(state);
  assign desc_nxt   = elem_desc(next_elem(state));
  assign active     = (state != IDLE) && (state != DONE);
  assign accept     = start && !active;
  assign cmp_active = active && desc.rd && phase;
  assign exp_val    = desc.exp_one ? {DW{1'b1}} : {DW{1'b0}};
  assign mismatch   = cmp_active && (ram_do != exp_val);

  // Next-state and address-generator control.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    ag_load   = 1'b0;
    ag_down   = 1'b0;
    ag_step   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = W0_UP;
          phase_nxt = 1'b0;
          ag_load   = 1'b1;
        end else begin
          state_nxt = state;
        end
      end
      default: begin
`ifndef RAM_BIST_ERR_COUNT_EN
        if (mismatch) begin
          state_nxt = DONE;
          phase_nxt = 1'b0;
        end else
`endif
        if (desc.rd && !phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (last) begin
            state_nxt = next_elem(state);
            ag_load   = 1'b1;
            ag_down   = desc_nxt.down;
          end else begin
            ag_step = 1'b1;
          end
        end
      end
    endcase
  end

  // RAM port decode; the final r0 element leaves the port idle in its compare cycle.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = {AW{1'b0}};
    ram_di   = {DW{1'b0}};
    if (active) begin
      ram_addr = addr;
      if (!desc.rd) begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        ram_di = desc.wr_one ? {DW{1'b1}} : {DW{1'b0}};
      end else if (!phase) begin
        ram_en = 1'b1;
      end else begin
        ram_en = desc.wr;
        ram_we = desc.wr;
        ram_di = (desc.wr && desc.wr_one) ? {DW{1'b1}} : {DW{1'b0}};
      end
    end else begin
      ram_addr = {AW{1'b0}};
    end
  end

  // Sequencer state and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      busy  <= (state_nxt != IDLE) && (state_nxt != DONE);
      done  <= (state_nxt == DONE);
    end
  end

  // Result capture: first failing address/data and the final verdict.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      pass      <= 1'b0;
      fail_addr <= {AW{1'b0}};
      fail_data <= {DW{1'b0}};
      fail_seen <= 1'b0;
    end else begin
      if (mismatch && !fail_seen) begin
        fail_addr <= addr;
        fail_data <= ram_do;
        fail_seen <= 1'b1;
      end else begin
        fail_seen <= fail_seen;
      end
      if (active && (state_nxt == DONE)) begin
        pass <= !(fail_seen || mismatch);
      end else begin
        pass <= pass;
      end
    end
  end

`ifdef RAM_BIST_ERR_COUNT_EN
  // Saturating mismatch counter.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_cnt <= 8'd0;
    end else if (mismatch && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed self-checking bench for ram_bist_ctrl with a behavioural 32x4 RAM
// that can model one stuck-at fault.
module tb_ram_bist_ctrl;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ram_en, ram_we, busy, done, pass;
  logic [AW-1:0] ram_addr, fail_addr;
  logic [DW-1:0] ram_di, fail_data;
  logic [DW-1:0] ram_do = 4'd0;
`ifdef RAM_BIST_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cur = 0;
  int fault_addr = -1;
  logic [DW-1:0] sa0_mask = 4'd0;
  logic [DW-1:0] sa1_mask = 4'd0;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  ram_bist_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data)
`ifdef RAM_BIST_ERR_COUNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= (int'(ram_addr) == fault_addr) ? ((ram_di & ~sa0_mask) | sa1_mask) : ram_di;
        ram_do <= 4'd0;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cur = 0;
  endtask

  task automatic go_to(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_di, busy, done, pass, fail_addr, fail_data} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {ram_en, ram_we, ram_addr, ram_di, busy, done, pass, fail_addr, fail_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_full_run();
    int n_busy = 0;
    int n_en = 0;
    fault_addr = -1;
    do_start();
    for (int k = 1; k <= 353; k++) begin
      go_to(k);
      if (busy) n_busy++;
      if (ram_en) n_en++;
      if (k == 1 || k == 33 || k == 34 || k == 98 || k == 161) begin
        logic [10:0] exp;
        case (k)
          1:       exp = {1'b1, 1'b1, 5'd0, 4'h0};
          33:      exp = {1'b1, 1'b0, 5'd0, 4'h0};
          34:      exp = {1'b1, 1'b1, 5'd0, 4'hF};
          98:      exp = {1'b1, 1'b1, 5'd0, 4'h0};
          default: exp = {1'b1, 1'b0, 5'd31, 4'h0};
        endcase
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_di} !== exp) begin
          errors++;
          $display("FAIL full_port_c%0d: got %h want %h", k, {ram_en, ram_we, ram_addr, ram_di}, exp);
        end
      end
      if (k == 352) begin
        checks++;
        if ({ram_en, busy, done} !== 3'b010) begin
          errors++;
          $display("FAIL full_last_cmp: got en/busy/done=%b want 010", {ram_en, busy, done});
        end
      end
    end
    checks++;
    if ({done, pass, busy, ram_en, ram_addr} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL full_done: got done/pass/busy/en/addr=%b want 1100_00000",
               {done, pass, busy, ram_en, ram_addr});
    end
    checks++;
    if (n_busy !== 352 || n_en !== 320) begin
      errors++;
      $display("FAIL full_cycles: got busy=%0d en=%0d want 352 320", n_busy, n_en);
    end
  endtask

  task automatic test_stuck_at0();
    fault_addr = 9;
    sa0_mask = 4'b0100;
    sa1_mask = 4'b0000;
    do_start();
    go_to(116);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_di, busy} !== {1'b1, 1'b1, 5'd9, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL sa0_cmp_cycle: got %h want %h", {ram_en, ram_we, ram_addr, ram_di, busy},
               {1'b1, 1'b1, 5'd9, 4'h0, 1'b1});
    end
`ifdef RAM_BIST_ERR_COUNT_EN
    go_to(353);
    checks++;
    if ({done, pass, fail_addr, fail_data, err_cnt} !== {1'b1, 1'b0, 5'd9, 4'b1011, 8'd2}) begin
      errors++;
      $display("FAIL sa0_result: got done=%b pass=%b addr=%0d data=%b cnt=%0d want 1 0 9 1011 2",
               done, pass, fail_addr, fail_data, err_cnt);
    end
`else
    go_to(117);
    checks++;
    if ({done, pass, busy, ram_en, fail_addr, fail_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 4'b1011}) begin
      errors++;
      $display("FAIL sa0_result: got done=%b pass=%b busy=%b en=%b addr=%0d data=%b want 1 0 0 0 9 1011",
               done, pass, busy, ram_en, fail_addr, fail_data);
    end
    go_to(125);
    checks++;
    if (ram_en !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL sa0_idle_after: got en=%b done=%b want 0 1", ram_en, done);
    end
`endif
  endtask

  task automatic test_rerun_after_fail();
    fault_addr = -1;
    do_start();
    go_to(1);
    checks++;
    if ({done, pass, fail_addr, fail_data, busy} !== {1'b0, 1'b0, 5'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL rerun_clear: got done=%b pass=%b addr=%0d data=%b busy=%b want 0 0 0 0 1",
               done, pass, fail_addr, fail_data, busy);
    end
    go_to(353);
    checks++;
    if ({done, pass} !== 2'b11) begin
      errors++;
      $display("FAIL rerun_pass: got done/pass=%b want 11", {done, pass});
    end
  endtask

  task automatic test_reset_midrun();
    fault_addr = -1;
    do_start();
    go_to(100);
    rst = 1'b1;
    go_to(101);
    checks++;
    if ({ram_en, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_reset: got en/busy/done=%b want 000", {ram_en, busy, done});
    end
    start = 1'b1;
    go_to(102);
    start = 1'b0;
    rst = 1'b0;
    go_to(103);
    checks++;
    if ({ram_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_over_start: got en/busy=%b want 00", {ram_en, busy});
    end
    do_start();
    go_to(353);
    checks++;
    if ({done, pass, busy} !== 3'b110) begin
      errors++;
      $display("FAIL midrun_rerun: got done/pass/busy=%b want 110", {done, pass, busy});
    end
  endtask

  task automatic test_start_ignored();
    fault_addr = -1;
    do_start();
    for (int k = 1; k <= 353; k++) begin
      go_to(k);
      if (k == 201) begin
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 5'd11}) begin
          errors++;
          $display("FAIL ignore_seq: got en/we/addr=%h want %h", {ram_en, ram_we, ram_addr},
                   {1'b1, 1'b0, 5'd11});
        end
      end
      if (k == 352) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL ignore_early_done: got done=%b want 0", done);
        end
      end
      start = (k == 50 || k == 200);
    end
    start = 1'b0;
    checks++;
    if ({done, pass} !== 2'b11) begin
      errors++;
      $display("FAIL ignore_done: got done/pass=%b want 11", {done, pass});
    end
  endtask

  task automatic test_stuck_at1();
    fault_addr = 31;
    sa0_mask = 4'b0000;
    sa1_mask = 4'b0001;
    do_start();
`ifdef RAM_BIST_ERR_COUNT_EN
    go_to(352);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL sa1_running: got busy/done=%b want 10", {busy, done});
    end
    go_to(353);
    checks++;
    if ({done, pass, fail_addr, fail_data, err_cnt} !== {1'b1, 1'b0, 5'd31, 4'b0001, 8'd3}) begin
      errors++;
      $display("FAIL sa1_result: got done=%b pass=%b addr=%0d data=%b cnt=%0d want 1 0 31 0001 3",
               done, pass, fail_addr, fail_data, err_cnt);
    end
`else
    go_to(96);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_di} !== {1'b1, 1'b1, 5'd31, 4'hF}) begin
      errors++;
      $display("FAIL sa1_cmp_cycle: got %h want %h", {ram_en, ram_we, ram_addr, ram_di},
               {1'b1, 1'b1, 5'd31, 4'hF});
    end
    go_to(97);
    checks++;
    if ({done, pass, ram_en, fail_addr, fail_data} !== {1'b1, 1'b0, 1'b0, 5'd31, 4'b0001}) begin
      errors++;
      $display("FAIL sa1_result: got done=%b pass=%b en=%b addr=%0d data=%b want 1 0 0 31 0001",
               done, pass, ram_en, fail_addr, fail_data);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stuck_at0();
    test_rerun_after_fail();
    test_reset_midrun();
    test_start_ignored();
    test_stuck_at1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
